mixcol_seq: RTL and testbench

MIXCOL_SEQ -- requirements
Module: mixcol_seq

---
 rtl/aes_pkg.sv | 17 +
 rtl/mix_single_column.sv | 30 +++
 rtl/mixcol_seq.sv | 96 +++++++++
 tb/tb_mixcol_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the MixColumns sequencer.
// xtime multiplies a byte by x modulo the reduction polynomial.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [7:0] XTIME_POLY_DEFAULT = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] b, input logic [7:0] poly);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns on one 32-bit column (row 0 in the MSB byte).
module mix_single_column
  import aes_pkg::*;
#(
  parameter logic [7:0] XTIME_POLY = XTIME_POLY_DEFAULT
) (
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] x0, x1, x2, x3;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  assign x0 = xtime(a0, XTIME_POLY);
  assign x1 = xtime(a1, XTIME_POLY);
  assign x2 = xtime(a2, XTIME_POLY);
  assign x3 = xtime(a3, XTIME_POLY);

  // 3*a is xtime(a) ^ a
  assign col_o[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
  assign col_o[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
  assign col_o[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
  assign col_o[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;

endmodule

// File: rtl/mixcol_seq.sv
// Column-serial MixColumns: one column per cycle through a shared mixer,
// then the result is held until the downstream handshake.
//
// state | meaning
// IDLE  | ready for a new state
// MIX   | mixing column col_q this cycle
// HOLD  | result presented on out_data, waiting for out_ready
module mixcol_seq
  import aes_pkg::*;
#(
  parameter logic [7:0] XTIME_POLY = XTIME_POLY_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  state_e        state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [127:0]  data_q, data_d;
  logic [31:0]   col_in, col_mixed;
  logic          accept;

  assign accept = in_valid & (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      data_q  <= 128'd0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = in_bypass ? HOLD : MIX;
      MIX:  if (col_q == 2'd3) state_d = HOLD;
      HOLD: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == HOLD);
    busy      = (state_q != IDLE);
    out_data  = out_valid ? data_q : 128'd0;
  end

  always_comb begin
    col_in = data_q[127:96];
    case (col_q)
      2'd0: col_in = data_q[127:96];
      2'd1: col_in = data_q[95:64];
      2'd2: col_in = data_q[63:32];
      2'd3: col_in = data_q[31:0];
      default: col_in = data_q[127:96];
    endcase
  end

  mix_single_column #(.XTIME_POLY(XTIME_POLY)) u_mix (
    .col_i(col_in),
    .col_o(col_mixed)
  );

  always_comb begin
    data_d = data_q;
    col_d  = col_q;
    if (accept) begin
      data_d = in_data;
      col_d  = 2'd0;
    end else if (state_q == MIX) begin
      col_d = col_q + 2'd1;
      case (col_q)
        2'd0: data_d[127:96] = col_mixed;
        2'd1: data_d[95:64]  = col_mixed;
        2'd2: data_d[63:32]  = col_mixed;
        2'd3: data_d[31:0]   = col_mixed;
        default: data_d = data_q;
      endcase
    end
  end

endmodule

// File: tb/tb_mixcol_seq.sv
// Directed and randomized checks of mixcol_seq against a byte-level
// MixColumns reference built from GF(2^8) multiplication.
module tb_mixcol_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mixcol_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_bypass(in_bypass),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_model(input logic [127:0] d, input logic byp);
    logic [7:0]   coef [4];
    logic [7:0]   s [4][4];
    logic [127:0] r;
    logic [7:0]   acc;
    coef[0] = 8'd2; coef[1] = 8'd3; coef[2] = 8'd1; coef[3] = 8'd1;
    if (byp) return d;
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++)
        s[c][k] = d[127 - 32*c - 8*k -: 8];
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(coef[(k - rr + 4) % 4], s[c][k]);
        r[127 - 32*c - 8*rr -: 8] = acc;
      end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one state, wait for the accept, then wait for out_valid.
  task automatic send_and_get(input logic [127:0] d, input logic byp, input int exp_lat,
                              output logic [127:0] got);
    int g = 0;
    int lat;
    in_valid  = 1'b1;
    in_data   = d;
    in_bypass = byp;
    while (!in_ready && g < 50) begin step(); g++; end
    check("accept_ready", {127'd0, in_ready}, 128'd1);
    step();
    in_valid  = 1'b0;
    in_data   = rand128();
    in_bypass = $urandom_range(1);
    lat = 1;
    while (!out_valid && lat < 50) begin step(); lat++; end
    if (exp_lat > 0) check("latency", lat, exp_lat);
    got = out_data;
  endtask

  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] BYP_IN   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ISO_IN   = 128'hdb135345f20a225c01010101c6c6c6c6;
  localparam logic [127:0] ISO_OUT  = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;

  initial begin
    logic [127:0] got, r1, r2, exp1, pend_d;
    logic         pend_b, have_pend;
    logic [127:0] exp_q [$];
    int sent, rcvd, g;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_bypass = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    check("rst_in_ready", {127'd0, in_ready}, 128'd1);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_out_data", out_data, 128'd0);

    // FIPS-197 vector
    out_ready = 1'b1;
    send_and_get(FIPS_IN, 1'b0, 5, got);
    check("fips_data", got, FIPS_OUT);
    step();
    check("fips_idle", {127'd0, in_ready}, 128'd1);

    // Bypass
    send_and_get(BYP_IN, 1'b1, 1, got);
    check("bypass_data", got, BYP_IN);
    step();

    // Column isolation
    send_and_get(ISO_IN, 1'b0, 5, got);
    check("iso_data", got, ISO_OUT);
    step();

    // Backpressure with a competing input held valid
    r1 = rand128(); r2 = rand128();
    exp1 = ref_model(r1, 1'b0);
    out_ready = 1'b0;
    send_and_get(r1, 1'b0, 5, got);
    check("bp_first", got, exp1);
    in_valid = 1'b1; in_data = r2; in_bypass = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_stable", out_data, exp1);
      check("bp_in_ready", {127'd0, in_ready}, 128'd0);
    end
    out_ready = 1'b1;
    step();
    check("bp_idle_ready", {127'd0, in_ready}, 128'd1);
    check("bp_idle_valid", {127'd0, out_valid}, 128'd0);
    step();
    in_valid = 1'b0;
    check("bp_next_accept", {127'd0, busy}, 128'd1);
    g = 0;
    while (!out_valid && g < 50) begin step(); g++; end
    check("bp_second", out_data, ref_model(r2, 1'b0));
    step();

    // Reset while col==2
    in_valid = 1'b1; in_data = FIPS_IN; in_bypass = 1'b0;
    step();
    in_valid = 1'b0;
    step(); step();
    check("mid_busy", {127'd0, busy}, 128'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_ready", {127'd0, in_ready}, 128'd1);
    check("mid_rst_busy", {127'd0, busy}, 128'd0);
    check("mid_rst_valid", {127'd0, out_valid}, 128'd0);
    check("mid_rst_data", out_data, 128'd0);
    send_and_get(FIPS_IN, 1'b0, 5, got);
    check("fips_rerun", got, FIPS_OUT);
    step();

    // Random traffic with random valid/ready
    sent = 0; rcvd = 0; have_pend = 1'b0; pend_d = '0; pend_b = 1'b0;
    for (int cyc = 0; cyc < 3000 && rcvd < 20; cyc++) begin
      if (!have_pend && sent < 20) begin
        pend_d = rand128();
        pend_b = ($urandom_range(3) == 0);
        have_pend = 1'b1;
      end
      in_valid  = have_pend && ($urandom_range(1) == 1);
      in_data   = in_valid ? pend_d : rand128();
      in_bypass = in_valid ? pend_b : 1'($urandom_range(1));
      out_ready = ($urandom_range(1) == 1);
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(pend_d, pend_b));
        have_pend = 1'b0;
        sent++;
      end
      if (!out_valid) check("rnd_zero", out_data, 128'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) check("rnd_data", out_data, exp_q.pop_front());
        else check("rnd_extra", out_data, 'x);
        rcvd++;
      end
      step();
    end
    in_valid = 1'b0;
    check("rnd_count", rcvd, 20);
    check("rnd_leftover", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
